ppc_fetch_queue: RTL

Instruction fetch and prefetch buffer sitting directly upstream of the PPC execute core. It owns the fetch PC, reads aligned 64-bit doublewords from memory read port 0, splits them into 32-bit big-endian instruction words, and buffers them in a small FIFO. The core consumes them through a valid/ready handshake. Branch redirects from the core flush the queue and restart fetch at the new target.

---
 rtl/ppc_pkg.sv | 14 +
 rtl/ppc_fetch_fifo.sv | 52 +++++
 rtl/ppc_fetch_queue.sv | 79 +++++++
 3 files changed

// File: rtl/ppc_pkg.sv
// Shared PPC fetch-path widths and the fetch queue entry type.
// Bit numbering is big-endian: bit 0 is the MSB.
package ppc_pkg;

  localparam int INSN_W    = 32;
  localparam int DW_ADDR_W = 61;
  localparam int ADDR_W    = 64;

  typedef struct packed {
    logic [0:INSN_W-1] inst;
    logic [0:ADDR_W-1] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ppc_fetch_fifo.sv
// Instruction queue: up to two writes and one read per cycle, synchronous flush.
// Head is visible combinationally from storage; the caller guarantees room for writes.
module ppc_fetch_fifo
  import ppc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr0_en,
  input  logic         wr1_en,
  input  fetch_entry_t wr0_dat,
  input  fetch_entry_t wr1_dat,
  input  logic         rd_en,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [1:0]    wr_n;
  logic          rd;

  assign wr_n = {1'b0, wr0_en} + {1'b0, wr1_en};
  assign rd   = rd_en && (count != '0);
  assign head = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero before the first fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr0_en) mem[wr_ptr] <= wr0_dat;
      if (wr0_en && wr1_en) mem[wr_ptr + PW'(1)] <= wr1_dat;
      wr_ptr <= wr_ptr + PW'(wr_n);
      if (rd) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_n) - CW'(rd);
    end
  end

endmodule

// File: rtl/ppc_fetch_queue.sv
// Fetch/prefetch unit: owns the fetch PC, splits doublewords into two words, queues them.
// Redirect flushes the queue and refetches the target on the next edge.
module ppc_fetch_queue
  import ppc_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [0:ADDR_W-1] RESET_PC = 64'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [0:DW_ADDR_W-1] mem_addr,
  input  logic [0:63]          mem_data,
  output logic                 inst_valid,
  output logic [0:INSN_W-1]    inst,
  output logic [0:ADDR_W-1]    inst_pc,
  input  logic                 inst_ready,
  input  logic                 redirect_valid,
  input  logic [0:ADDR_W-1]    redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [0:ADDR_W-1] fpc;
  logic [0:ADDR_W-1] fpc_nxt;
  logic [CW-1:0]     count;
  logic [CW-1:0]     free;
  logic              wr0_en;
  logic              wr1_en;
  fetch_entry_t      wr0_dat;
  fetch_entry_t      wr1_dat;
  fetch_entry_t      head;

  assign mem_addr = fpc[0:DW_ADDR_W-1];
  // Free space ignores a same-cycle dequeue, so the queue never needs a bypass.
  assign free = CW'(DEPTH) - count;

  always_comb begin
    wr0_en       = 1'b0;
    wr1_en       = 1'b0;
    fpc_nxt      = fpc;
    wr0_dat.inst = fpc[61] ? mem_data[32:63] : mem_data[0:31];
    wr0_dat.pc   = fpc;
    wr1_dat.inst = mem_data[32:63];
    wr1_dat.pc   = fpc + 64'd4;
    if (redirect_valid) begin
      fpc_nxt = redirect_pc & ~64'd3;
    end else if (!fpc[61] && free >= CW'(2)) begin
      wr0_en  = 1'b1;
      wr1_en  = 1'b1;
      fpc_nxt = fpc + 64'd8;
    end else if (free != '0) begin
      wr0_en  = 1'b1;
      fpc_nxt = fpc + 64'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fpc <= RESET_PC;
    else        fpc <= fpc_nxt;
  end

  ppc_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .wr0_en  (wr0_en),
    .wr1_en  (wr1_en),
    .wr0_dat (wr0_dat),
    .wr1_dat (wr1_dat),
    .rd_en   (inst_valid && inst_ready),
    .head    (head),
    .count   (count)
  );

  assign inst_valid = (count != '0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

endmodule
